stereo_dac_output: RTL and testbench



---
 rtl/stereo_dac_output.sv | 175 +++++++++++++++++
 tb/tb_stereo_dac_output.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stereo_dac_output.sv
// stereo_dac_output: two-channel audio output stage.
// Each 18-bit signed sample pair is linearly interpolated over 32 steps of
// TICK_DIV clocks. Each channel then feeds a 1-bit sigma-delta modulator that
// runs at the full clock rate.
// Optional build macro DAC_SD_2ND_ORDER_EN: when it is defined, each channel
// uses a second-order error-feedback modulator. When it is undefined, each
// channel uses a first-order accumulator, which is the default.
module stereo_dac_output #(
    parameter int INTERP_LOG2 = 5,
    parameter int TICK_DIV    = 65,
    parameter int DATA_W      = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_in_rdy,
    input  logic [DATA_W-1:0] sample_in_l,
    input  logic [DATA_W-1:0] sample_in_r,
    output logic              dac_out_l,
    output logic              dac_out_r
);
    localparam int ACC_W  = DATA_W + INTERP_LOG2;
    localparam int STEPS  = 1 << INTERP_LOG2;
    localparam int STEP_W = INTERP_LOG2 + 1;
    localparam int TICK_W = $clog2(TICK_DIV);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              tick_fire;
    logic              ramp_en;

    // A tick fires on the last count. A strobe has priority over a tick that lands on the same edge.
    assign tick_fire = (tick_q == TICK_W'(TICK_DIV - 1));
    assign ramp_en   = tick_fire && (step_q < STEP_W'(STEPS)) && !sample_in_rdy;

    // Next state of the shared tick/step counters; a strobe restarts both.
    always_comb begin
        tick_d = tick_fire ? '0 : tick_q + TICK_W'(1);
        step_d = ramp_en ? step_q + STEP_W'(1) : step_q;
        if (sample_in_rdy) begin
            tick_d = '0;
            step_d = '0;
        end
    end

    // Shared counters. The step counter parks at STEPS while no ramp is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
            step_q <= STEP_W'(STEPS);
        end else begin
            tick_q <= tick_d;
            step_q <= step_d;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [DATA_W-1:0]        samp;
        logic signed [DATA_W-1:0] prev_q, prev_d;
        logic signed [DATA_W-1:0] target_q, target_d;
        logic signed [DATA_W:0]   diff;
        logic signed [ACC_W-1:0]  yacc_q, yacc_d;
        logic signed [DATA_W-1:0] y;
        logic                     dac_q;

        if (ch == 0) begin : g_left
            assign samp      = sample_in_l;
            assign dac_out_l = dac_q;
        end else begin : g_right
            assign samp      = sample_in_r;
            assign dac_out_r = dac_q;
        end

        // The slope is a 19-bit difference, so a full-scale swing never wraps.
        assign diff = {target_q[DATA_W-1], target_q} - {prev_q[DATA_W-1], prev_q};
        // The interpolated value is the top DATA_W bits of the accumulator, which is an arithmetic shift.
        assign y    = yacc_q[ACC_W-1:INTERP_LOG2];

        // Interpolator next state. A strobe snaps the accumulator to the old target; each tick adds one slope step.
        always_comb begin
            prev_d   = prev_q;
            target_d = target_q;
            yacc_d   = yacc_q;
            if (sample_in_rdy) begin
                prev_d   = target_q;
                target_d = samp;
                yacc_d   = {target_q, {INTERP_LOG2{1'b0}}};
            end else if (ramp_en) begin
                yacc_d = yacc_q + {{(ACC_W - DATA_W - 1){diff[DATA_W]}}, diff};
            end
        end

        // Interpolator registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                prev_q   <= '0;
                target_q <= '0;
                yacc_q   <= '0;
            end else begin
                prev_q   <= prev_d;
                target_q <= target_d;
                yacc_q   <= yacc_d;
            end
        end

`ifdef DAC_SD_2ND_ORDER_EN
        localparam int I1_W = 22;
        localparam int I2_W = 26;
        logic signed [I1_W-1:0] i1_q, i1_d;
        logic signed [I2_W-1:0] i2_q, i2_d;
        logic [I1_W+1:0]        i1_sum;
        logic [I2_W+1:0]        i2_sum;
        logic [DATA_W:0]        fb;
        logic                   dac_d;

        // The feedback is +/- half of full scale, selected by the bit already on the pin.
        assign fb = dac_q ? {2'b01, {(DATA_W - 1){1'b0}}} : {2'b11, {(DATA_W - 1){1'b0}}};

        // Two saturating integrators. The second integrator takes the freshly updated first one (a CIFB loop), so the noise transfer is (1 - z^-1)^2.
        always_comb begin
            i1_sum = {{2{i1_q[I1_W-1]}}, i1_q}
                   + {{(I1_W + 2 - DATA_W){y[DATA_W-1]}}, y}
                   - {{(I1_W + 1 - DATA_W){fb[DATA_W]}}, fb};
            if ((i1_sum[I1_W+1:I1_W-1] == 3'b000) || (i1_sum[I1_W+1:I1_W-1] == 3'b111))
                i1_d = i1_sum[I1_W-1:0];
            else if (i1_sum[I1_W+1])
                i1_d = {1'b1, {(I1_W - 1){1'b0}}};
            else
                i1_d = {1'b0, {(I1_W - 1){1'b1}}};

            i2_sum = {{2{i2_q[I2_W-1]}}, i2_q}
                   + {{(I2_W + 2 - I1_W){i1_d[I1_W-1]}}, i1_d}
                   - {{(I2_W + 1 - DATA_W){fb[DATA_W]}}, fb};
            if ((i2_sum[I2_W+1:I2_W-1] == 3'b000) || (i2_sum[I2_W+1:I2_W-1] == 3'b111))
                i2_d = i2_sum[I2_W-1:0];
            else if (i2_sum[I2_W+1])
                i2_d = {1'b1, {(I2_W - 1){1'b0}}};
            else
                i2_d = {1'b0, {(I2_W - 1){1'b1}}};

            dac_d = ~i2_d[I2_W-1];
        end

        // Second-order modulator state and the registered output bit.
        always_ff @(posedge clk) begin
            if (reset) begin
                i1_q  <= '0;
                i2_q  <= '0;
                dac_q <= 1'b0;
            end else begin
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                dac_q <= dac_d;
            end
        end
`else
        logic [DATA_W-1:0] sd_acc_q;
        logic [DATA_W:0]   sd_sum;

        // Converting to offset binary only needs the sign bit flipped. The carry out of the sum is the output bit.
        assign sd_sum = {1'b0, sd_acc_q} + {1'b0, ~y[DATA_W-1], y[DATA_W-2:0]};

        // First-order accumulator and the registered output bit.
        always_ff @(posedge clk) begin
            if (reset) begin
                sd_acc_q <= '0;
                dac_q    <= 1'b0;
            end else begin
                sd_acc_q <= sd_sum[DATA_W-1:0];
                dac_q    <= sd_sum[DATA_W];
            end
        end
`endif
    end

endmodule

// File: tb/tb_stereo_dac_output.sv
// Testbench for stereo_dac_output.
// The driver applies one input set per clock. For each clock it advances a
// behavioural model (interpolated value in closed form, plus modulator
// arithmetic) and pushes the expected {dac_out_l, dac_out_r} into exp_q.
// A monitor on the falling edge pops exp_q and compares each entry.
// Windowed ones-density checks cover the DC cases.
module tb_stereo_dac_output;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        sample_in_rdy;
    logic [17:0] sample_in_l;
    logic [17:0] sample_in_r;
    logic        dac_out_l;
    logic        dac_out_r;

    always #5 clk = ~clk;

    stereo_dac_output dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in_rdy(sample_in_rdy),
        .sample_in_l  (sample_in_l),
        .sample_in_r  (sample_in_r),
        .dac_out_l    (dac_out_l),
        .dac_out_r    (dac_out_r)
    );

`ifdef DAC_SD_2ND_ORDER_EN
    localparam int TOL = 16;
`else
    localparam int TOL = 1;
`endif

    // ---------------- scoreboard state ----------------
    logic [1:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         ones_l = 0;
    int         ones_r = 0;

    // ---------------- reference model ----------------
    // Model state per channel: the previous and current targets and the
    // interpolated value y. The output bit and modulator state are also kept.
    longint m_prev[2];
    longint m_target[2];
    longint m_y[2];
    longint m_acc[2];
    longint m_i1[2];
    longint m_i2[2];
    int     m_dac[2];
    int     m_since;   // clocks since the last accepted strobe

    function automatic longint sat(input longint v, input int bits);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (bits - 1)) - 1;
        lo = -(longint'(1) <<< (bits - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    task automatic model_edge(input logic rst, input logic rdy, input longint in_l, input longint in_r);
        longint s;
        longint fb;
        longint k;
        longint in_v[2];
        in_v[0] = in_l;
        in_v[1] = in_r;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_prev[c] = 0; m_target[c] = 0; m_y[c] = 0;
                m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_dac[c] = 0;
            end
            m_since = 1000000;
        end else begin
            // The modulator sees y as it stood before this edge.
            for (int c = 0; c < 2; c++) begin
`ifdef DAC_SD_2ND_ORDER_EN
                fb       = (m_dac[c] != 0) ? 131072 : -131072;
                m_i1[c]  = sat(m_i1[c] + m_y[c] - fb, 22);
                m_i2[c]  = sat(m_i2[c] + m_i1[c] - fb, 26);
                m_dac[c] = (m_i2[c] >= 0) ? 1 : 0;
`else
                s        = m_acc[c] + m_y[c] + 131072;
                m_dac[c] = (s >= 262144) ? 1 : 0;
                m_acc[c] = s % 262144;
`endif
            end
            if (rdy) begin
                for (int c = 0; c < 2; c++) begin
                    m_prev[c]   = m_target[c];
                    m_target[c] = in_v[c];
                end
                m_since = 0;
            end else if (m_since < 1000000) begin
                m_since++;
            end
            // The ramp completes one step every 65 clocks, for at most 32 steps.
            k = m_since / 65;
            if (k > 32) k = 32;
            for (int c = 0; c < 2; c++)
                m_y[c] = (m_prev[c] * 32 + k * (m_target[c] - m_prev[c])) >>> 5;
        end
        exp_q.push_back({m_dac[0][0], m_dac[1][0]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic rst, input logic rdy, input logic [17:0] l, input logic [17:0] r);
        reset         = rst;
        sample_in_rdy = rdy;
        sample_in_l   = l;
        sample_in_r   = r;
        @(posedge clk);
        model_edge(rst, rdy, longint'($signed(l)), longint'($signed(r)));
        #1;
        ones_l += int'(dac_out_l);
        ones_r += int'(dac_out_r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 18'($urandom), 18'($urandom));
    endtask

    task automatic strobe(input logic [17:0] l, input logic [17:0] r);
        cycle(1'b0, 1'b1, l, r);
    endtask

    task automatic measure(input int n, output int cl, output int cr);
        ones_l = 0;
        ones_r = 0;
        idle(n);
        cl = ones_l;
        cr = ones_r;
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            checks++;
            if ({dac_out_l, dac_out_r} !== e) begin
                errors++;
                $display("FAIL dac_lr cycle %0d got %b expected %b", cyc, {dac_out_l, dac_out_r}, e);
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    initial begin
        int cl;
        int cr;
        reset         = 1'b1;
        sample_in_rdy = 1'b0;
        sample_in_l   = '0;
        sample_in_r   = '0;

        // Reset held for 100 clocks while random data and strobes are driven.
        for (int i = 0; i < 100; i++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 18'($urandom), 18'($urandom));

        // After release with no strobe, y is 0 and the output density is 50%.
        idle(20);
        measure(256, cl, cr);
        check_range("idle_density_l", cl, 128 - TOL, 128 + TOL);
        check_range("idle_density_r", cr, 128 - TOL, 128 + TOL);

        // DC input of L=0 and R=32768, strobed every 2080 clocks.
        strobe(18'd0, 18'd32768);
        idle(2079);
        for (int p = 0; p < 5; p++) begin
            strobe(18'd0, 18'd32768);
            measure(2048, cl, cr);
            check_range("dc_density_l", cl, 1024 - TOL, 1024 + TOL);
            check_range("dc_density_r", cr, 1280 - TOL, 1280 + TOL);
            idle(31);
        end
`ifdef DAC_SD_2ND_ORDER_EN
        measure(8192, cl, cr);
        check_range("dc_density_r_8192", cr, 5120 - 16, 5120 + 16);
`endif

        // Interpolation ramp from a target of 0 to L=32000.
        strobe(18'd0, 18'd0);
        idle(2100);
        strobe(18'd32000, 18'($signed(-18'sd32000)));
        idle(2200);

        // An early strobe restarts the ramp from the old target.
        strobe(18'd50000, 18'($signed(-18'sd70000)));
        idle(1000);
        strobe(18'($signed(-18'sd90000)), 18'd120000);
        idle(2200);

        // Full scale on both channels, then a 10000-clock window once the ramp has settled.
        strobe(18'h20000, 18'h1FFFF);
        idle(2100);
        strobe(18'h20000, 18'h1FFFF);
        idle(10);
        measure(10000, cl, cr);
`ifndef DAC_SD_2ND_ORDER_EN
        check_range("fullscale_l", cl, 0, 0);
        check_range("fullscale_r", cr, 9999, 10000);
`endif

        // Random samples, with strobe spacing both shorter and longer than the sample period.
        for (int i = 0; i < 8; i++) begin
            strobe(18'($urandom), 18'($urandom));
            idle($urandom_range(100, 3000));
        end

        // Reset asserted partway through a ramp.
        strobe(18'd100000, 18'($signed(-18'sd100000)));
        idle(500);
        cycle(1'b1, 1'b0, 18'($urandom), 18'($urandom));
        cycle(1'b1, 1'b1, 18'($urandom), 18'($urandom));
        idle(20);
        measure(256, cl, cr);
        check_range("post_reset_density_l", cl, 128 - TOL, 128 + TOL);
        check_range("post_reset_density_r", cr, 128 - TOL, 128 + TOL);

        // Every expected entry must have been compared.
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drain got %0d entries left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
